// File: rtl/fifo_read_ctrl_pkg.sv
// Shared types and constants for the fifo_read_ctrl drain stage:
// FSM state encodings, default data width and the buffer credit check.
package fifo_read_ctrl_pkg;

  // FSM state encodings; also driven out on stateOut.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_ERROR = 2'b11
  } state_t;

  // Default width of FIFO words and dataOut.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Output buffer depth and occupancy counter width.
  localparam int BUF_DEPTH = 2;
  localparam int OCC_WIDTH = 2;

  // Width of the FILL timeout counter (FILL_TIMEOUT is limited to 1..255).
  localparam int TO_WIDTH = 8;

  // A new read may be issued only if every word already committed to the
  // buffer (stored plus in flight, minus the one leaving this cycle) still
  // leaves a free slot. This keeps the 2-entry buffer from overflowing.
  function automatic logic has_credit(
    input logic [OCC_WIDTH-1:0] occ,
    input logic                 inflight,
    input logic                 pop
  );
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (committed < 3'(BUF_DEPTH));
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_skid_buf2.sv
// Two-entry FIFO-ordered register buffer (skid_buf2) between the FIFO
// capture point and the valid/ready output. Push and pop may coincide.
module fifo_read_ctrl_skid_buf2
  import fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid
);

  logic [OCC_WIDTH-1:0]  occ_reg;
  logic [DATA_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0] tail_reg;
  logic                  pop_ok;
  logic                  push_ok;

  // Ignore a pop of an empty buffer and a push into a full one that is not
  // also popping; the credit rule upstream should never produce either.
  assign pop_ok  = pop  & (occ_reg != '0);
  assign push_ok = push & ((occ_reg != OCC_WIDTH'(BUF_DEPTH)) | pop_ok);

  // Storage update: head_reg is always the oldest word, tail_reg the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg  <= '0;
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (occ_reg == '0) begin
            head_reg <= push_data;
          end else begin
            tail_reg <= push_data;
          end
          occ_reg <= occ_reg + 1'b1;
        end
        2'b01: begin
          head_reg <= tail_reg;
          occ_reg  <= occ_reg - 1'b1;
        end
        2'b11: begin
          // Occupancy stays the same; the new word lands behind whatever
          // remains after the head leaves.
          if (occ_reg == OCC_WIDTH'(1)) begin
            head_reg <= push_data;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign occ   = occ_reg;
  assign head  = head_reg;
  assign valid = (occ_reg != '0);

endmodule

// File: rtl/fifo_read_ctrl.sv
// Drain stage for an 8-bit FIFO: waits in FILL until the FIFO is above its
// almost-empty threshold (or a timeout expires), then streams words through
// a 2-entry output buffer onto a valid/ready interface. A read that hits an
// empty FIFO traps the block in a sticky ERROR state until ENB is dropped.
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int FILL_TIMEOUT = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENB,
  input  logic                  outEmpty,
  input  logic                  almostEmpty,
  input  logic                  errorEmpty,
  input  logic [DATA_WIDTH-1:0] fifoData,
  output logic                  sRead,
  input  logic                  readyIn,
  output logic                  validOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  errorOut,
  output logic [1:0]            stateOut,
  output logic [CNT_WIDTH-1:0]  wordCount
);

  // Last count value of a full timeout window (counter starts at zero on
  // FILL entry, so FILL_TIMEOUT non-empty cycles end at FILL_TIMEOUT-1).
  localparam logic [TO_WIDTH-1:0] TIMEOUT_LAST = TO_WIDTH'(FILL_TIMEOUT - 1);

  state_t                 state_reg;
  logic                   error_reg;
  logic                   inflight_reg;
  logic [TO_WIDTH-1:0]    timeout_reg;
  logic [CNT_WIDTH-1:0]   word_count_reg;

  logic [OCC_WIDTH-1:0]   occ;
  logic                   buf_valid;
  logic [DATA_WIDTH-1:0]  buf_head;
  logic                   push;
  logic                   pop;
  logic                   underflow;
  logic                   timeout_hit;
  logic                   fill_go;
  logic                   timeout_run;

  // The word returned for last cycle's read is bad if the FIFO flags it.
  assign underflow = inflight_reg & errorEmpty;

  // Capture every good in-flight word; a flagged word is dropped.
  assign push = inflight_reg & ~errorEmpty;

  // Downstream handshake completes whenever the buffer head is offered
  // and accepted, in any FSM state.
  assign pop = buf_valid & readyIn;

  // FILL gives up waiting for the threshold once the FIFO has been
  // non-empty for a full timeout window.
  assign timeout_hit = ~outEmpty & (timeout_reg == TIMEOUT_LAST);
  assign fill_go     = ENB & (~almostEmpty | timeout_hit);

  // The timeout keeps counting only while FILL persists with data waiting.
  assign timeout_run = (state_reg == ST_FILL) & ENB & ~underflow &
                       ~outEmpty & ~fill_go;

  // Read strobe: only in DRAIN, only with data available and buffer credit.
  // readyIn feeds in through pop so a draining buffer frees credit at once.
  assign sRead = (state_reg == ST_DRAIN) & ENB & ~outEmpty &
                 has_credit(occ, inflight_reg, pop);

  // Main FSM with the sticky error flag; underflow outranks every exit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      error_reg <= 1'b0;
    end else if (underflow) begin
      state_reg <= ST_ERROR;
      error_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ENB) begin
            state_reg <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (!ENB) begin
            state_reg <= ST_IDLE;
          end else if (fill_go) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!ENB) begin
            state_reg <= ST_IDLE;
          end else if (outEmpty && !inflight_reg) begin
            state_reg <= ST_FILL;
          end
        end
        ST_ERROR: begin
          if (!ENB) begin
            state_reg <= ST_IDLE;
            error_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // FILL timeout counter: clears on an empty FIFO or whenever FILL ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timeout_reg <= '0;
    end else if (timeout_run) begin
      timeout_reg <= timeout_reg + 1'b1;
    end else begin
      timeout_reg <= '0;
    end
  end

  // Remember that a read was issued; its data arrives next cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= sRead;
    end
  end

  // Count delivered words, wrapping naturally at the counter width.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      word_count_reg <= '0;
    end else if (pop) begin
      word_count_reg <= word_count_reg + 1'b1;
    end
  end

  fifo_read_ctrl_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (push),
    .push_data (fifoData),
    .pop       (pop),
    .occ       (occ),
    .head      (buf_head),
    .valid     (buf_valid)
  );

  assign validOut  = buf_valid;
  assign dataOut   = buf_head;
  assign errorOut  = error_reg;
  assign stateOut  = state_reg;
  assign wordCount = word_count_reg;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a per-cycle vector table for a short
// stream, plus hand-written sequences driven by a tiny FIFO model.
module tb_fifo_read_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ENB = 1'b0;
  logic        outEmpty = 1'b1;
  logic        almostEmpty = 1'b1;
  logic        errorEmpty = 1'b0;
  logic [7:0]  fifoData = 8'h00;
  logic        sRead;
  logic        readyIn = 1'b0;
  logic        validOut;
  logic [7:0]  dataOut;
  logic        errorOut;
  logic [1:0]  stateOut;
  logic [15:0] wordCount;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] q[$];
  int         ae_thr = 0;

  fifo_read_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENB         (ENB),
    .outEmpty    (outEmpty),
    .almostEmpty (almostEmpty),
    .errorEmpty  (errorEmpty),
    .fifoData    (fifoData),
    .sRead       (sRead),
    .readyIn     (readyIn),
    .validOut    (validOut),
    .dataOut     (dataOut),
    .errorOut    (errorOut),
    .stateOut    (stateOut),
    .wordCount   (wordCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       enb;
    logic       oe;
    logic       ae;
    logic       rdy;
    logic [7:0] data;
    logic       x_sread;
    logic       x_valid;
    logic [7:0] x_data;
    logic [1:0] x_state;
    logic [15:0] x_wc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic upd_flags();
    outEmpty    = (q.size() == 0);
    almostEmpty = (q.size() <= ae_thr);
  endtask

  task automatic settle();
    #2;
  endtask

  // One clock: the FIFO model services a read sampled before the edge.
  task automatic step();
    logic rd;
    rd = sRead;
    @(posedge CLK);
    #1;
    if (rd && q.size() > 0) fifoData = q.pop_front();
    upd_flags();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    ENB = 1'b0;
    readyIn = 1'b0;
    errorEmpty = 1'b0;
    fifoData = 8'h00;
    q.delete();
    ae_thr = 0;
    upd_flags();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  // Advance until sRead is seen (bounded); returns cycles waited or -1.
  task automatic wait_sread(output int cyc);
    cyc = -1;
    for (int k = 0; k < 40; k++) begin
      settle();
      if (sRead) begin
        cyc = k;
        return;
      end
      step();
    end
  endtask

  initial begin
    int   found;
    int   nrd;
    int   first_rd;
    int   last_rd;
    int   first_dl;
    int   last_dl;
    logic [7:0] got[$];

    // Stream of three words A1..A3 with a short readyIn stall at the end.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd1, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 2'd2, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 2'd2, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, 8'hA1, 2'd2, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA2, 2'd2, 16'd1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 2'd2, 16'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 2'd1, 16'd2};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA3, 2'd1, 16'd2};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd1, 16'd3};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 16'd3};

    // ---- Reset values ----
    do_reset();
    settle();
    chk("rst_sread", sRead, 1'b0);
    chk("rst_valid", validOut, 1'b0);
    chk("rst_data", dataOut, 8'h00);
    chk("rst_error", errorOut, 1'b0);
    chk("rst_state", stateOut, 2'd0);
    chk("rst_wc", wordCount, 16'd0);
    $display("reset: state=%0d valid=%0b wc=%0d", stateOut, validOut, wordCount);

    // ---- Vector table ----
    for (int i = 0; i < 11; i++) begin
      ENB = vecs[i].enb;
      outEmpty = vecs[i].oe;
      almostEmpty = vecs[i].ae;
      readyIn = vecs[i].rdy;
      fifoData = vecs[i].data;
      settle();
      $display("vec %0d: sRead=%0b valid=%0b data=%02h state=%0d wc=%0d",
               i, sRead, validOut, dataOut, stateOut, wordCount);
      chk($sformatf("vec%0d_sread", i), sRead, vecs[i].x_sread);
      chk($sformatf("vec%0d_valid", i), validOut, vecs[i].x_valid);
      if (vecs[i].x_valid) chk($sformatf("vec%0d_data", i), dataOut, vecs[i].x_data);
      chk($sformatf("vec%0d_state", i), stateOut, vecs[i].x_state);
      chk($sformatf("vec%0d_wc", i), wordCount, vecs[i].x_wc);
      @(posedge CLK);
      #1;
    end

    // ---- Threshold start via timeout ----
    do_reset();
    q = '{8'h01, 8'h02, 8'h03};
    ae_thr = 8;
    upd_flags();
    readyIn = 1'b1;
    ENB = 1'b1;
    settle();
    step();
    settle();
    chk("to_fill_entry", stateOut, 2'd1);
    found = -1;
    for (int k = 0; k < 20; k++) begin
      if (sRead) begin
        found = k;
        break;
      end
      step();
      settle();
    end
    $display("timeout start: first sRead %0d cycles after FILL entry", found);
    chk("to_first_sread", found, 8);

    // ---- Threshold start via almostEmpty drop in FILL cycle 3 ----
    do_reset();
    q = '{8'h01, 8'h02, 8'h03};
    ae_thr = 8;
    upd_flags();
    readyIn = 1'b1;
    ENB = 1'b1;
    settle();
    step();
    settle();
    found = -1;
    for (int k = 0; k < 20; k++) begin
      if (sRead) begin
        found = k;
        break;
      end
      if (k == 3) begin
        ae_thr = 0;
        upd_flags();
      end
      step();
      settle();
    end
    $display("threshold start: first sRead %0d cycles after FILL entry", found);
    chk("ae_first_sread", found, 4);

    // ---- Streaming 0x11..0x16 ----
    do_reset();
    q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    upd_flags();
    readyIn = 1'b1;
    ENB = 1'b1;
    nrd = 0; first_rd = -1; last_rd = -1; first_dl = -1; last_dl = -1;
    got.delete();
    for (int k = 0; k < 20; k++) begin
      settle();
      if (sRead) begin
        nrd++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
      end
      if (validOut && readyIn) begin
        got.push_back(dataOut);
        if (first_dl < 0) first_dl = k;
        last_dl = k;
        $display("stream: delivered %02h at cycle %0d", dataOut, k);
      end
      step();
    end
    settle();
    chk("stream_nread", nrd, 6);
    chk("stream_read_span", last_rd - first_rd, 5);
    chk("stream_ndeliv", got.size(), 6);
    chk("stream_deliv_span", last_dl - first_dl, 5);
    chk("stream_latency", first_dl - first_rd, 2);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream_word%0d", i), (i < got.size()) ? got[i] : 8'hxx, 8'h11 + 8'(i));
    end
    chk("stream_wc", wordCount, 16'd6);
    chk("stream_state", stateOut, 2'd1);

    // ---- Backpressure ----
    do_reset();
    q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    upd_flags();
    readyIn = 1'b0;
    ENB = 1'b1;
    nrd = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (sRead) nrd++;
      step();
    end
    settle();
    $display("backpressure: %0d reads while stalled, head=%02h", nrd, dataOut);
    chk("bp_nread_stalled", nrd, 2);
    chk("bp_sread_low", sRead, 1'b0);
    chk("bp_valid", validOut, 1'b1);
    chk("bp_head", dataOut, 8'h21);
    readyIn = 1'b1;
    got.delete();
    for (int k = 0; k < 20; k++) begin
      settle();
      if (sRead) nrd++;
      if (validOut && readyIn) begin
        got.push_back(dataOut);
        $display("backpressure: delivered %02h", dataOut);
      end
      step();
    end
    chk("bp_nread_total", nrd, 5);
    chk("bp_ndeliv", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_word%0d", i), (i < got.size()) ? got[i] : 8'hxx, 8'h21 + 8'(i));
    end

    // ---- Asynchronous reset with a full buffer ----
    do_reset();
    q = '{8'h41, 8'h42, 8'h43, 8'h44};
    upd_flags();
    readyIn = 1'b0;
    ENB = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      step();
    end
    settle();
    chk("ar_pre_valid", validOut, 1'b1);
    RST = 1'b0;
    #1;
    $display("async reset: state=%0d valid=%0b data=%02h", stateOut, validOut, dataOut);
    chk("ar_sread", sRead, 1'b0);
    chk("ar_valid", validOut, 1'b0);
    chk("ar_data", dataOut, 8'h00);
    chk("ar_state", stateOut, 2'd0);
    chk("ar_error", errorOut, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    settle();
    chk("ar_release_sread", sRead, 1'b0);
    chk("ar_release_state", stateOut, 2'd0);

    // ---- Underflow trap ----
    do_reset();
    q = '{8'h5A};
    upd_flags();
    readyIn = 1'b1;
    ENB = 1'b1;
    wait_sread(found);
    chk("uf_sread_seen", (found >= 0), 1'b1);
    step();
    errorEmpty = 1'b1;
    settle();
    step();
    errorEmpty = 1'b0;
    settle();
    $display("underflow: state=%0d errorOut=%0b valid=%0b", stateOut, errorOut, validOut);
    chk("uf_state", stateOut, 2'd3);
    chk("uf_error", errorOut, 1'b1);
    chk("uf_valid", validOut, 1'b0);
    step();
    step();
    settle();
    chk("uf_sticky_state", stateOut, 2'd3);
    chk("uf_sticky_valid", validOut, 1'b0);
    chk("uf_wc", wordCount, 16'd0);
    ENB = 1'b0;
    settle();
    step();
    settle();
    chk("uf_exit_state", stateOut, 2'd0);
    chk("uf_exit_error", errorOut, 1'b0);

    // ---- Disable mid-burst ----
    do_reset();
    q = '{8'h31, 8'h32, 8'h33, 8'h34};
    upd_flags();
    readyIn = 1'b1;
    ENB = 1'b1;
    wait_sread(found);
    chk("dis_sread_seen", (found >= 0), 1'b1);
    step();
    ENB = 1'b0;
    settle();
    chk("dis_no_sread", sRead, 1'b0);
    nrd = 0;
    got.delete();
    for (int k = 0; k < 6; k++) begin
      step();
      settle();
      if (sRead) nrd++;
      if (validOut && readyIn) begin
        got.push_back(dataOut);
        $display("disable: delivered %02h", dataOut);
      end
    end
    chk("dis_nread", nrd, 0);
    chk("dis_ndeliv", got.size(), 1);
    chk("dis_word", (got.size() > 0) ? got[0] : 8'hxx, 8'h31);
    chk("dis_state", stateOut, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
